round_sequencer: RTL
====================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 100000000, clk cycles per one-second game tick.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level, high while the game controller is in its in-game phase.
REQ-005 mode  input  1  0 = timed round, 1 = word-count round.
REQ-006 target  input  7  round length: seconds (mode 0) or words (mode 1), sampled at round start.
REQ-007 char_ok  input  1  one-cycle pulse, correctly typed character.
REQ-008 char_err  input  1  one-cycle pulse, mistyped character.
REQ-009 word_done  input  1  one-cycle pulse, word completed.
REQ-010 pause  input  1  freeze request (used only with ROUND_SEQ_PAUSE_EN).
REQ-011 finish  output  1  level, high in DONE state.
REQ-012 busy  output  1  level, high in RUN state.
REQ-013 remaining  output  7  seconds (mode 0) or words (mode 1) left.
REQ-014 elapsed  output  7  whole seconds since round start.
REQ-015 correct_cnt  output  10  correct characters this round.
REQ-016 error_cnt  output  10  mistyped characters this round.
REQ-017 words  output  7  words completed this round.

Function
REQ-018 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-019 IDLE with run=1: next cycle load remaining=target, clear elapsed/counters/prescaler, latch mode; go RUN, or DONE directly if target=0.
REQ-020 RUN: prescaler counts 0..TICK_CYCLES-1; tick asserted on the cycle it wraps, first tick exactly TICK_CYCLES cycles after RUN entry.
REQ-021 Each tick: elapsed increments, saturating at 127.
REQ-022 Mode 0: each tick decrements remaining; tick taking remaining 1->0 moves FSM to DONE next edge.
REQ-023 Mode 1: word_done increments words and decrements remaining; word_done taking remaining 1->0 moves FSM to DONE.
REQ-024 char_ok increments correct_cnt, char_err increments error_cnt, both saturating at 1023.
REQ-025 char_ok and char_err in the same cycle: only error_cnt increments.
REQ-026 Events coincident with the finishing tick/word are counted; events in IDLE or DONE are ignored.
REQ-027 RUN with run=0: abort to IDLE next edge, counters hold their values, finish stays 0.
REQ-028 DONE: finish=1, all counters frozen; run=0 returns to IDLE.
REQ-029 Counters and remaining hold last values in IDLE until next round start (for result display).
REQ-030 mode and target changes after round start have no effect until next round.

Reset
REQ-031 rst_n low asynchronously forces IDLE, finish=0, busy=0, remaining=0, elapsed=0, correct_cnt=0, error_cnt=0, words=0, prescaler=0.
REQ-032 Reset mid-round discards the round; run still high after release starts a fresh round per REQ-019.

Configuration
REQ-033 Macro ROUND_SEQ_PAUSE_EN defined: pause=1 in RUN freezes prescaler and ignores char_ok/char_err/word_done; run=0 still aborts.
REQ-034 Macro undefined: pause port present but ignored, no pause logic synthesized.

Verification (TICK_CYCLES=4)
REQ-035 mode=0, target=3, run high -> busy 1; remaining 3,2,1,0 at 4-cycle intervals; finish=1 one cycle after reaching 0; elapsed=3.
REQ-036 mode=1, target=2, two word_done pulses 10 cycles apart -> words=2, remaining=0, finish=1 next cycle; no further tick effect.
REQ-037 RUN, char_ok and char_err same cycle, then 3 char_ok -> correct_cnt=3, error_cnt=1.
REQ-038 run dropped after 6 cycles in RUN -> IDLE, finish=0, elapsed=1 held; run high again -> counters cleared, fresh round.
REQ-039 target=0, run high -> DONE directly, finish=1, busy never asserted.
REQ-040 ROUND_SEQ_PAUSE_EN, mode=0, target=2, pause high 8 cycles mid-round -> finish delayed by exactly 8 cycles, char_ok during pause not counted.

Source files
------------

// File: rtl/round_sequencer.sv
// Round sequencer for the typing game: tracks one timed or word-count round and its statistics.
// Optional freeze input is compiled in with `define ROUND_SEQ_PAUSE_EN.
module round_sequencer #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       mode,
    input  logic [6:0] target,
    input  logic       char_ok,
    input  logic       char_err,
    input  logic       word_done,
    input  logic       pause,
    output logic       finish,
    output logic       busy,
    output logic [6:0] remaining,
    output logic [6:0] elapsed,
    output logic [9:0] correct_cnt,
    output logic [9:0] error_cnt,
    output logic [6:0] words
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   prescale_reg;
    logic            mode_reg;

    logic            active;
    logic            tick;

`ifdef ROUND_SEQ_PAUSE_EN
    assign active = ~pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign active       = 1'b1;
`endif

    assign tick = (prescale_reg == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            prescale_reg <= '0;
            mode_reg     <= 1'b0;
            finish       <= 1'b0;
            busy         <= 1'b0;
            remaining    <= '0;
            elapsed      <= '0;
            correct_cnt  <= '0;
            error_cnt    <= '0;
            words        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    if (run) begin
                        remaining    <= target;
                        elapsed      <= '0;
                        correct_cnt  <= '0;
                        error_cnt    <= '0;
                        words        <= '0;
                        prescale_reg <= '0;
                        mode_reg     <= mode;
                        if (target == 7'd0) begin
                            state_reg <= DONE;
                            finish    <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (!run) begin
                        // Abort: results stay visible, no finish indication.
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        finish    <= 1'b0;
                    end else begin
                        // Remaining reached zero on the previous edge; finish one cycle later.
                        if (remaining == 7'd0) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            finish    <= 1'b1;
                        end
                        if (active) begin
                            prescale_reg <= tick ? '0 : prescale_reg + 1'b1;
                            if (tick) begin
                                if (elapsed != 7'h7F)
                                    elapsed <= elapsed + 7'd1;
                                if (!mode_reg && remaining != 7'd0)
                                    remaining <= remaining - 7'd1;
                            end
                            if (char_err) begin
                                if (error_cnt != 10'h3FF)
                                    error_cnt <= error_cnt + 10'd1;
                            end else if (char_ok) begin
                                if (correct_cnt != 10'h3FF)
                                    correct_cnt <= correct_cnt + 10'd1;
                            end
                            if (word_done) begin
                                if (words != 7'h7F)
                                    words <= words + 7'd1;
                                if (mode_reg && remaining != 7'd0)
                                    remaining <= remaining - 7'd1;
                            end
                        end
                    end
                end

                DONE: begin
                    if (!run) begin
                        state_reg <= IDLE;
                        finish    <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    finish    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
